nyq_coef_loader: RTL and testbench
==================================

# nyq_coef_loader

Coefficient load sequencer for the Nyquist filter. It accepts a stream of filter coefficients over a valid/ready handshake and writes them into the filter's parameter memory at addresses 0..NUM_COEF-1, through the standard WrEn/Addr/PAR write port. It brackets every load with a write of 0 and then 1 to the load-done flag word, so the filter's tap counter is halted during a reload and restarts cleanly afterwards. It sits between the external configuration interface and the NYQ block's parameter port.

## Interface
- ADDR_WIDTH, 11, parameter memory address width (matches NYQ)
- MEM_WIDTH, 24, parameter word width
- NUM_COEF, 1024, coefficients per load (4 phases × OSR 256)
- FLAG_ADDR, 1024, address of the load-done flag word; bit 0 enables the filter
- Clk_CI  in  1  clock; single clock domain
- Rst_RBI  in  1  asynchronous, active-low reset
- Start_SI  in  1  one-cycle pulse; begins a load sequence when in IDLE
- Abort_SI  in  1  cancels an in-progress load
- Coef_DI  in  MEM_WIDTH  signed coefficient word
- CoefValid_SI  in  1  Coef_DI is valid
- CoefReady_SO  out  1  loader accepts Coef_DI this cycle
- WrEn_SO  out  1  write enable to NYQ WrEn_SI
- Addr_DO  out  ADDR_WIDTH  write address to NYQ Addr_DI
- PAR_Out_DO  out  MEM_WIDTH  write data to NYQ PAR_In_DI
- Busy_SO  out  1  high while a sequence is active (CLR, LOAD, SET)
- Done_SO  out  1  one-cycle pulse when the flag has been written to 1
- CoefCnt_DO  out  ADDR_WIDTH  number of coefficients written in the current load

## Operation
- FSM states: IDLE, CLR, LOAD, SET, DONE.
- IDLE: all write outputs are low or zero. Start_SI=1 moves to CLR; CoefCnt_DO is cleared to 0.
- CLR: for one cycle, drive WrEn_SO=1, Addr_DO=FLAG_ADDR, PAR_Out_DO=0. Then go to LOAD.
- LOAD:
  - CoefReady_SO=1. A handshake is CoefValid_SI && CoefReady_SO.
  - On a handshake, the next cycle drives WrEn_SO=1, Addr_DO=CoefCnt_DO (pre-increment value), PAR_Out_DO=Coef_DI, and CoefCnt_DO increments.
  - No handshake means WrEn_SO=0 in the following cycle.
  - The handshake that brings the count to NUM_COEF deasserts CoefReady_SO from the next cycle onward and moves the FSM to SET, after that final write is issued.
- SET: for one cycle, drive WrEn_SO=1, Addr_DO=FLAG_ADDR, PAR_Out_DO=1. Then go to DONE.
- DONE: Done_SO=1 for one cycle, then return to IDLE. CoefCnt_DO holds NUM_COEF until the next Start_SI.
- Abort_SI in CLR, LOAD or SET:
  - Go to IDLE on the next edge.
  - Any write already registered from a prior-cycle handshake still completes. No further writes are issued, the flag is not set, and Done_SO is not pulsed.
  - Effect: the filter stays halted (flag=0) until a full reload completes.
- Abort_SI and Start_SI asserted together in IDLE: Abort wins and the block stays in IDLE.
- Start_SI while Busy_SO=1: ignored.
- Width rules:
  - Coefficients pass through unmodified at full MEM_WIDTH.
  - The flag write data is zero-extended to MEM_WIDTH.
  - CoefCnt_DO never exceeds NUM_COEF; the write address never reaches FLAG_ADDR during LOAD.
- WrEn_SO is never high for two different addresses in the same cycle. At most one write is issued per cycle.

## Timing
- All outputs are registered. Reset values: CoefReady_SO=0, WrEn_SO=0, Addr_DO=0, PAR_Out_DO=0, Busy_SO=0, Done_SO=0, CoefCnt_DO=0. The FSM resets to IDLE.
- Reset mid-sequence returns the block to IDLE immediately, with all outputs at reset values.
- Start_SI sampled at edge t:
  - Busy_SO=1 and the CLR write are visible after edge t.
  - CoefReady_SO=1 from edge t+1.
- Coefficient latency: a handshake at edge k produces a write visible from edge k to k+1. Equivalently, WrEn_SO is registered from the same edge that samples the handshake.
- Minimum sequence length with CoefValid_SI held high: 1 (CLR) + NUM_COEF (LOAD) + 1 (SET) + 1 (DONE) cycles from Start_SI to IDLE. That is NUM_COEF+3 cycles.
- Busy_SO falls in the same cycle that Done_SO rises.

## Test plan
- Reset, then Start, then 1024 coefficients with valid held high:
  - Writes observed: flag←0, addr 0..1023 ← data i, then flag←1.
  - Done_SO pulses exactly once, 1027 cycles after Start.
  - CoefCnt_DO=1024.
- Valid toggled at random over a full load (~50% duty): same write sequence, no gaps in addresses, no duplicate addresses, CoefReady_SO=0 outside LOAD.
- Abort after 300 coefficients:
  - Last write is to addr 299.
  - No flag←1 write and no Done_SO.
  - Busy_SO=0 one cycle later.
  - A subsequent Start reloads from addr 0 with flag←0 first.
- Start pulsed repeatedly during LOAD: the write sequence is unaffected and exactly one Done_SO occurs.
- Rst_RBI low at coefficient 512: all outputs go to 0 immediately and the FSM is in IDLE after release.
- Integration with NYQ, NUM_COEF=1024:
  - The NYQ counter stays at 0 while the flag is 0.
  - The counter starts incrementing after the flag←1 write.
  - With impulse input, NYQ_Out_DO matches the loaded coefficient sums.

Source files
------------

// File: rtl/nyq_coef_loader.sv
// nyq_coef_loader: streams NUM_COEF coefficients into NYQ parameter memory, bracketed by flag<-0 / flag<-1 writes.
module nyq_coef_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int MEM_WIDTH  = 24,
  parameter int NUM_COEF   = 1024,
  parameter int FLAG_ADDR  = 1024
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Start_SI,
  input  logic                  Abort_SI,
  input  logic [MEM_WIDTH-1:0]  Coef_DI,
  input  logic                  CoefValid_SI,
  output logic                  CoefReady_SO,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic [ADDR_WIDTH-1:0] CoefCnt_DO
);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, SET, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(NUM_COEF - 1);
  localparam logic [ADDR_WIDTH-1:0] FLAG     = ADDR_WIDTH'(FLAG_ADDR);
  state_t                  state_q, state_d;
  logic                    hs, set_wr;
  logic                    wr_d;
  logic [ADDR_WIDTH-1:0]   addr_d, cnt_d;
  logic [MEM_WIDTH-1:0]    par_d;
  // Abort suppresses the handshake in the same cycle, so no write follows it.
  assign hs     = state_q == LOAD && CoefReady_SO && CoefValid_SI && !Abort_SI;
  assign set_wr = state_q == SET && !Abort_SI;
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q      <= IDLE;
      CoefReady_SO <= 1'b0;
      WrEn_SO      <= 1'b0;
      Addr_DO      <= '0;
      PAR_Out_DO   <= '0;
      Busy_SO      <= 1'b0;
      Done_SO      <= 1'b0;
      CoefCnt_DO   <= '0;
    end else begin
      state_q      <= state_d;
      CoefReady_SO <= state_d == LOAD;
      WrEn_SO      <= wr_d;
      Addr_DO      <= addr_d;
      PAR_Out_DO   <= par_d;
      Busy_SO      <= state_d != IDLE;
      Done_SO      <= state_q == DONE;
      CoefCnt_DO   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (Start_SI && !Abort_SI) ? CLR : IDLE;
      CLR:     state_d = Abort_SI ? IDLE : LOAD;
      LOAD:    state_d = Abort_SI ? IDLE : (hs && CoefCnt_DO == LAST_CNT) ? SET : LOAD;
      SET:     state_d = Abort_SI ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wr_d   = (state_q == IDLE && state_d == CLR) || hs || set_wr;
    addr_d = hs ? CoefCnt_DO : wr_d ? FLAG : '0;
    par_d  = hs ? Coef_DI : set_wr ? MEM_WIDTH'(1) : '0;
    cnt_d  = (state_q == IDLE && state_d == CLR) ? '0 : hs ? CoefCnt_DO + 1'b1 : CoefCnt_DO;
  end
endmodule

// File: tb/tb_nyq_coef_loader.sv
// tb_nyq_coef_loader: randomized load sequences checked against an expected write list built from coefficient arrays.
module tb_nyq_coef_loader;
  localparam int AW = 11;
  localparam int MW = 24;
  localparam int NC = 1024;
  localparam int FA = 1024;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, valid = 1'b0;
  logic [MW-1:0] coef_d = '0;
  logic          ready, wr_en, busy, done;
  logic [AW-1:0] addr, cnt;
  logic [MW-1:0] par;
  int            total = 0, bad = 0;
  int            cyc = 0, ndone = 0, done_cyc = 0, viol = 0;
  int            wa[$];
  int            wd[$];
  logic [MW-1:0] coef[NC];
  nyq_coef_loader #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW), .NUM_COEF(NC), .FLAG_ADDR(FA)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Abort_SI(abort),
    .Coef_DI(coef_d), .CoefValid_SI(valid), .CoefReady_SO(ready), .WrEn_SO(wr_en),
    .Addr_DO(addr), .PAR_Out_DO(par), .Busy_SO(busy), .Done_SO(done), .CoefCnt_DO(cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(addr));
      wd.push_back(int'(par));
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    if ((ready && !busy) || (done && busy) || (wr_en && !busy && !done)) viol++;
  end
  // Expected log: flag<-0, then coef[i] at address i for i<n, then flag<-1 if the load completes.
  function automatic int first_diff(input int n, input bit set);
    int len, ea, ed;
    len = 1 + n + int'(set);
    for (int i = 0; i < len; i++) begin
      ea = (i == 0 || (set && i == len - 1)) ? FA : i - 1;
      ed = (i == 0) ? 0 : (set && i == len - 1) ? 1 : int'(coef[i-1]);
      if (i >= wa.size() || wa[i] != ea || wd[i] != ed) return i;
    end
    return (wa.size() == len) ? -1 : len;
  endfunction
  task automatic run_load(input int stop_at, input bit rnd, input bit spam, output int start_cyc, output int cnt0);
    int  idx;
    bit  hs;
    for (int i = 0; i < NC; i++) coef[i] = MW'($urandom);
    wa.delete();
    wd.delete();
    ndone = 0;
    viol = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    cnt0 = int'(cnt);
    idx = 0;
    hs = 1'b0;
    for (int c = 0; c < 5000 && idx < NC; c++) begin
      valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_d = coef[idx];
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      hs = valid && ready;
      @(negedge clk);
      if (hs) idx++;
      if (stop_at != 0 && idx == stop_at) break;
    end
    valid = 1'b0;
    start = 1'b0;
    if (stop_at == 0)
      for (int c = 0; c < 20 && ndone == 0; c++) @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({ready, wr_en, addr, par, busy, done, cnt} !== '0) begin
      bad++;
      $display("FAIL reset_values got=%h want=0", {ready, wr_en, addr, par, busy, done, cnt});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b wr=%b want 0 0", busy, wr_en);
    end
  endtask
  task automatic test_full();
    int sc, c0, d;
    run_load(0, 1'b0, 1'b0, sc, c0);
    d = first_diff(NC, 1'b1);
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL full_seq first_bad_index=%0d want none (writes=%0d want %0d)", d, wa.size(), NC + 2);
    end
    total++;
    if (ndone != 1 || done_cyc - sc != NC + 3) begin
      bad++;
      $display("FAIL full_done count=%0d latency=%0d want 1 and %0d", ndone, done_cyc - sc, NC + 3);
    end
    total++;
    if (int'(cnt) != NC || ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_end cnt=%0d ready=%b busy=%b want %0d 0 0", cnt, ready, busy, NC);
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL full_protocol violations=%0d want 0", viol);
    end
  endtask
  task automatic test_random_valid();
    int sc, c0, d;
    run_load(0, 1'b1, 1'b0, sc, c0);
    d = first_diff(NC, 1'b1);
    total++;
    if (d != -1 || ndone != 1) begin
      bad++;
      $display("FAIL rand_seq first_bad_index=%0d done=%0d want none and 1", d, ndone);
    end
    total++;
    if (c0 != 0 || viol != 0) begin
      bad++;
      $display("FAIL rand_start cnt_after_start=%0d violations=%0d want 0 0", c0, viol);
    end
  endtask
  task automatic test_abort();
    int sc, c0, d;
    run_load(300, 1'b1, 1'b0, sc, c0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy busy=%b ready=%b want 0 0", busy, ready);
    end
    repeat (5) @(negedge clk);
    d = first_diff(300, 1'b0);
    total++;
    if (d != -1 || wa.size() == 0 || wa[$] != 299 || ndone != 0) begin
      bad++;
      $display("FAIL abort_seq first_bad_index=%0d last_addr=%0d done=%0d want none 299 0", d, (wa.size() > 0) ? wa[$] : -1, ndone);
    end
    run_load(0, 1'b1, 1'b0, sc, c0);
    d = first_diff(NC, 1'b1);
    total++;
    if (d != -1 || ndone != 1) begin
      bad++;
      $display("FAIL abort_reload first_bad_index=%0d done=%0d want none and 1", d, ndone);
    end
  endtask
  task automatic test_start_spam();
    int sc, c0, d;
    run_load(0, 1'b1, 1'b1, sc, c0);
    repeat (3) @(negedge clk);
    d = first_diff(NC, 1'b1);
    total++;
    if (d != -1 || ndone != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL spam_seq first_bad_index=%0d done=%0d busy=%b want none 1 0", d, ndone, busy);
    end
  endtask
  task automatic test_midreset();
    int sc, c0, d;
    run_load(512, 1'b0, 1'b0, sc, c0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready, wr_en, addr, par, busy, done, cnt} !== '0) begin
      bad++;
      $display("FAIL midreset_values got=%h want=0", {ready, wr_en, addr, par, busy, done, cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || ready !== 1'b0 || ndone != 0) begin
      bad++;
      $display("FAIL midreset_idle busy=%b ready=%b done=%0d want 0 0 0", busy, ready, ndone);
    end
    run_load(0, 1'b0, 1'b0, sc, c0);
    d = first_diff(NC, 1'b1);
    total++;
    if (d != -1 || ndone != 1) begin
      bad++;
      $display("FAIL midreset_reload first_bad_index=%0d done=%0d want none and 1", d, ndone);
    end
  endtask
  task automatic test_start_abort_idle();
    wa.delete();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || wa.size() != 0) begin
      bad++;
      $display("FAIL start_abort_idle busy=%b writes=%0d want 0 0", busy, wa.size());
    end
  endtask
  initial begin
    test_reset();
    test_full();
    test_random_valid();
    test_abort();
    test_start_spam();
    test_midreset();
    test_start_abort_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
